// File: rtl/mac_seq_ctrl.sv
// Sequencing controller for one MAC unit (out = a*b + c) and its psum register.
// Optional macro RELU_OUT_EN clamps negative results to zero on out_psum only.
module mac_seq_ctrl #(
  parameter int bw      = 4,
  parameter int psum_bw = 16,
  parameter int len_bw  = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [len_bw-1:0]  len,
  input  logic               act_4b_mode,
  output logic               busy,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [bw-1:0]      in_act,
  input  logic [2*bw-1:0]    in_wgt,
  output logic [bw-1:0]      mac_a,
  output logic [bw-1:0]      mac_b,
  output logic [psum_bw-1:0] mac_c,
  input  logic [psum_bw-1:0] mac_out,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [psum_bw-1:0] out_psum,
  output logic               done,
  output logic [1:0]         state_dbg
);

  localparam int half = bw / 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HI   = 2'd2,
    OUT  = 2'd3
  } state_t;

  state_t              state, state_nxt;
  logic [psum_bw-1:0]  acc, acc_nxt;
  logic [len_bw-1:0]   rem, rem_nxt;
  logic                mode, mode_nxt;
  logic [half-1:0]     a_hi, a_hi_nxt;
  logic [bw-1:0]       w_hi, w_hi_nxt;
  logic                take;
  logic                last;

  // Handshakes: a word moves on a rising edge where in_valid && in_ready; a
  // result moves on an edge where out_valid && out_ready. Neither valid waits
  // on its ready, and in_ready/out_valid depend only on the state.
  assign take = (state == RUN) && in_valid;
  assign last = (rem == len_bw'(1));

  // Operands stay zero unless a MAC step really happens, so an idle MAC
  // returns acc unchanged.
  always_comb begin
    mac_a = '0;
    mac_b = '0;
    if (take) begin
      mac_a = mode ? in_act : {{(bw-half){1'b0}}, in_act[half-1:0]};
      mac_b = in_wgt[bw-1:0];
    end else if (state == HI) begin
      mac_a = {{(bw-half){1'b0}}, a_hi};
      mac_b = w_hi;
    end
  end

  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    rem_nxt   = rem;
    mode_nxt  = mode;
    a_hi_nxt  = a_hi;
    w_hi_nxt  = w_hi;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    done      = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          mode_nxt  = act_4b_mode;
          acc_nxt   = '0;
          rem_nxt   = len;
          state_nxt = (len == '0) ? OUT : RUN;
        end
      end
      RUN: begin
        in_ready = 1'b1;
        if (in_valid) begin
          acc_nxt = mac_out;
          rem_nxt = rem - len_bw'(1);
          if (last) begin
            // Odd length in 2-bit mode: the high half of the final word is dropped.
            state_nxt = OUT;
          end else if (!mode) begin
            a_hi_nxt  = in_act[2*half-1:half];
            w_hi_nxt  = in_wgt[2*bw-1:bw];
            state_nxt = HI;
          end
        end
      end
      HI: begin
        acc_nxt   = mac_out;
        rem_nxt   = rem - len_bw'(1);
        state_nxt = last ? OUT : RUN;
      end
      OUT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      acc   <= '0;
      rem   <= '0;
      mode  <= 1'b0;
      a_hi  <= '0;
      w_hi  <= '0;
    end else begin
      state <= state_nxt;
      acc   <= acc_nxt;
      rem   <= rem_nxt;
      mode  <= mode_nxt;
      a_hi  <= a_hi_nxt;
      w_hi  <= w_hi_nxt;
    end
  end

  assign busy      = (state != IDLE);
  assign mac_c     = acc;
  assign state_dbg = state;

`ifdef RELU_OUT_EN
  assign out_psum = ((state == OUT) && !acc[psum_bw-1]) ? acc : '0;
`else
  assign out_psum = (state == OUT) ? acc : '0;
`endif

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Directed plus short random bench for mac_seq_ctrl with a behavioural MAC and a
// result scoreboard; honours RELU_OUT_EN when computing expected results.
module tb_mac_seq_ctrl;

  localparam int BW    = 4;
  localparam int PSUM  = 16;
  localparam int LENBW = 8;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              start = 1'b0;
  logic [LENBW-1:0]  len = '0;
  logic              act_4b_mode = 1'b0;
  logic              busy;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [BW-1:0]     in_act = '0;
  logic [2*BW-1:0]   in_wgt = '0;
  logic [BW-1:0]     mac_a;
  logic [BW-1:0]     mac_b;
  logic [PSUM-1:0]   mac_c;
  logic [PSUM-1:0]   mac_out;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [PSUM-1:0]   out_psum;
  logic              done;
  logic [1:0]        state_dbg;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int hs_cnt   = 0;
  logic [PSUM-1:0] exp_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (in_valid && in_ready) hs_cnt <= hs_cnt + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // Behavioural MAC: unsigned activation, signed weight, wrap at PSUM bits
  logic signed [PSUM-1:0] a_ext, b_ext;
  assign a_ext   = {{(PSUM-BW){1'b0}}, mac_a};
  assign b_ext   = {{(PSUM-BW){mac_b[BW-1]}}, mac_b};
  assign mac_out = a_ext * b_ext + mac_c;

  mac_seq_ctrl #(.bw(BW), .psum_bw(PSUM), .len_bw(LENBW)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .len(len),
    .act_4b_mode(act_4b_mode), .busy(busy), .in_valid(in_valid),
    .in_ready(in_ready), .in_act(in_act), .in_wgt(in_wgt), .mac_a(mac_a),
    .mac_b(mac_b), .mac_c(mac_c), .mac_out(mac_out), .out_valid(out_valid),
    .out_ready(out_ready), .out_psum(out_psum), .done(done),
    .state_dbg(state_dbg)
  );

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [PSUM-1:0] expect_out(input logic [PSUM-1:0] raw);
`ifdef RELU_OUT_EN
    return raw[PSUM-1] ? '0 : raw;
`else
    return raw;
`endif
  endfunction

  function automatic int ws(input logic [3:0] w);
    return int'($signed(w));
  endfunction

  task automatic check_reset_outputs(input string tag);
    check(tag, {busy, in_ready, out_valid, done, mac_a, mac_b, mac_c, out_psum}, 32'd0);
    check({tag, "_state"}, state_dbg, 32'd0);
  endtask

  // ---------------- driver tasks ----------------
  task automatic start_job(input logic [LENBW-1:0] l, input logic m);
    start = 1'b1; len = l; act_4b_mode = m;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_word(input logic [3:0] act, input logic [7:0] wgt);
    int waited = 0;
    in_act = act; in_wgt = wgt; in_valid = 1'b1;
    #1;
    while (in_ready !== 1'b1 && waited < 50) begin
      @(negedge clk); #1; waited++;
    end
    check("in_ready_seen", in_ready, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic collect();
    int waited = 0;
    logic [PSUM-1:0] exp;
    while (out_valid !== 1'b1 && waited < 50) begin
      @(negedge clk); waited++;
    end
    check("out_valid_seen", out_valid, 32'd1);
    if (exp_q.size() == 0) begin
      check("exp_q_nonempty", 32'd0, 32'd1);
    end else if (out_valid === 1'b1) begin
      exp = exp_q.pop_front();
      check("out_psum", out_psum, exp);
      out_ready = 1'b1;
      #1;
      check("done_pulse", done, 32'd1);
      @(negedge clk);
      out_ready = 1'b0;
      #1;
      check("done_low_after", {done, out_valid}, 32'd0);
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int c0, h0;
    logic [3:0] ra[8];
    logic [7:0] rw[8];
    int rlen, rmode, nwords, sum;

    #1;
    check_reset_outputs("reset_init");
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check_reset_outputs("idle_after_reset");

    // 4b, len=3: 1*1 + 2*(-1) + 3*2 = 5, back-to-back
    exp_q.push_back(expect_out(16'd5));
    start_job(8'd3, 1'b1);
    check("busy_run", busy, 32'd1);
    c0 = cyc; h0 = hs_cnt;
    send_word(4'd1, 8'h01);
    send_word(4'd2, 8'h0F);
    send_word(4'd3, 8'h02);
    check("4b_cycles", cyc - c0, 32'd3);
    check("4b_handshakes", hs_cnt - h0, 32'd3);
    check("4b_valid_next", out_valid, 32'd1);
    collect();

    // 4b, len=1: 15 * -8 = -120 (activation is unsigned)
    exp_q.push_back(expect_out(16'hFF88));
    start_job(8'd1, 1'b1);
    send_word(4'd15, 8'h08);
    collect();

    // 2b, len=4: (1*1 + 3*-2) + (2*3 + 0*7) = 1
    exp_q.push_back(expect_out(16'd1));
    start_job(8'd4, 1'b0);
    h0 = hs_cnt;
    send_word(4'b1101, 8'hE1);
    check("hi_in_ready_low", in_ready, 32'd0);
    check("hi_state", state_dbg, 32'd2);
    send_word(4'b0010, 8'h73);
    check("hi2_in_ready_low", in_ready, 32'd0);
    check("2b_len4_handshakes", hs_cnt - h0, 32'd2);
    collect();

    // 2b, len=3: high half of word 2 ignored -> -5 + 6 = 1
    exp_q.push_back(expect_out(16'd1));
    start_job(8'd3, 1'b0);
    h0 = hs_cnt;
    send_word(4'b1101, 8'hE1);
    send_word(4'b0010, 8'h73);
    check("2b_len3_out_next", out_valid, 32'd1);
    check("2b_len3_handshakes", hs_cnt - h0, 32'd2);
    collect();

    // len=0, stalled output while start pulses
    exp_q.push_back(expect_out(16'd0));
    start_job(8'd0, 1'b1);
    check("len0_valid_next", out_valid, 32'd1);
    for (int i = 0; i < 5; i++) begin
      start = (i % 2 == 0); len = 8'd5;
      #1;
      check("stall_psum", out_psum, 32'd0);
      check("stall_busy_valid", {busy, out_valid}, 32'd3);
      @(negedge clk);
    end
    start = 1'b0;
    collect();
    @(negedge clk);
    check("idle_after_stall", {state_dbg, busy}, 32'd0);

    // Reset mid-RUN after one of three elements
    start_job(8'd3, 1'b1);
    send_word(4'd4, 8'h05);
    check("mid_run_acc", mac_c, 32'd20);
    reset_n = 1'b0;
    #1;
    check_reset_outputs("reset_mid_run");
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("no_output_after_abort", out_valid, 32'd0);

    // Fresh job: 2*3 + 2*3 = 12
    exp_q.push_back(expect_out(16'd12));
    start_job(8'd2, 1'b1);
    send_word(4'd2, 8'h03);
    send_word(4'd2, 8'h03);
    collect();

    // Result -5: 5 * -1
    exp_q.push_back(expect_out(16'hFFFB));
    start_job(8'd1, 1'b1);
    send_word(4'd5, 8'h0F);
    collect();

    // Short random jobs, expected value from the bench's own arithmetic
    for (int j = 0; j < 6; j++) begin
      rmode  = $urandom_range(0, 1);
      rlen   = $urandom_range(1, 6);
      nwords = rmode ? rlen : (rlen + 1) / 2;
      sum    = 0;
      for (int k = 0; k < nwords; k++) begin
        ra[k] = 4'($urandom_range(0, 15));
        rw[k] = 8'($urandom_range(0, 255));
        if (rmode != 0) begin
          sum += int'(ra[k]) * ws(rw[k][3:0]);
        end else begin
          sum += int'(ra[k][1:0]) * ws(rw[k][3:0]);
          if (2 * k + 1 < rlen) sum += int'(ra[k][3:2]) * ws(rw[k][7:4]);
        end
      end
      exp_q.push_back(expect_out(16'(sum)));
      start_job(8'(rlen), rmode[0]);
      for (int k = 0; k < nwords; k++) send_word(ra[k], rw[k]);
      collect();
    end

    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
